sub_bytes_engine: RTL and testbench
===================================

SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 Parameter: LANES, default 4, S-box lanes per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Any other LANES value SHALL cause an elaboration error.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 Port: in_valid  in  1  state_in and mode are valid.
REQ-006 Port: in_ready  out  1  block can accept a new state.
REQ-007 Port: mode  in  1  0 = forward SubBytes, 1 = inverse SubBytes.
REQ-008 Port: state_in  in  128  AES state; byte k = state_in[127-8k -: 8], k = 0..15.
REQ-009 Port: out_valid  out  1  state_out holds a completed result.
REQ-010 Port: out_ready  in  1  consumer accepts state_out.
REQ-011 Port: state_out  out  128  substituted state, same byte ordering as state_in.
REQ-012 Port: busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL equal !in_ready; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE with in_valid=1 SHALL, at that edge, load state_in into the working register, latch mode, clear lane counter cnt to 0, and enter RUN.
REQ-016 Each RUN cycle SHALL replace bytes cnt*LANES .. cnt*LANES+LANES-1 with S(byte) when mode=0 or InvS(byte) when mode=1, then increment cnt.
REQ-017 Tables SHALL be the FIPS-197 forward and inverse S-boxes exactly, all 256 entries, with no default or X outputs.
REQ-018 When the last group (cnt = 16/LANES-1) is substituted, the FSM SHALL enter DONE at the same edge.
REQ-019 Latency: out_valid SHALL rise exactly 16/LANES cycles after the accepting edge (LANES=16 -> 1, LANES=1 -> 16).
REQ-020 Bytes not yet processed SHALL hold their loaded value; processed bytes SHALL NOT be re-substituted.
REQ-021 In DONE, state_out SHALL hold stable while out_ready=0, for any number of cycles.
REQ-022 DONE with out_ready=1 SHALL complete the transfer and return to IDLE at that edge; in_ready SHALL rise the next cycle.
REQ-023 There is no input/output overlap: back-to-back throughput is one block per 16/LANES+2 cycles with out_ready held high.
REQ-024 in_valid, mode and state_in changes during RUN or DONE SHALL be ignored; the latched mode SHALL govern the whole block.
REQ-025 state_out SHALL reflect the working register at all times; it is meaningful only while out_valid=1.
REQ-026 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, cnt=0, working register 0 and latched mode 0, independent of clk.
REQ-028 During reset, outputs SHALL be in_ready=1 (IDLE), busy=0, out_valid=0, state_out=0.
REQ-029 Reset asserted during RUN or DONE SHALL abort the block with no output produced.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 LANES=4, mode=0, state_in=00010203_04050607_08090a0b_0c0d0e0f -> out_valid 4 cycles after accept; state_out=637c777b_f26b6fc5_3001672b_fed7ab76.
REQ-032 LANES=4, mode=1, same state_in -> state_out=52096ad5_3036a538_bf40a39e_81f3d7fb.
REQ-033 Exhaustive sweep over LANES in {1,16}, both modes, all 256 byte values -> InvS(S(x))=x and S(InvS(x))=x; latency 16 (LANES=1) and 1 (LANES=16); S(0x53)=0xed and InvS(0x00)=0x52.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE while in_valid toggles with new data -> state_out unchanged, in_ready=0; on release, one transfer occurs, then IDLE.
REQ-035 rst_n pulsed low mid-RUN (cnt=2, LANES=4), asynchronous to clk -> outputs go to reset values without a clock edge; the next block processes correctly.
REQ-036 mode flipped and state_in changed during RUN -> result matches the originally latched mode and data.

Source files
------------

// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - Multi-lane AES SubBytes / InvSubBytes engine
// Substitutes LANES bytes of a latched 128-bit state per cycle, then holds the result until taken.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    localparam int GROUPS = 16 / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            mode_q;
    logic [127:0]    work;
    logic [127:0]    work_next;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0, as the S-box definition requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    // Only the current lane group is rewritten; all other bytes pass through untouched.
    always_comb begin
        work_next = work;
        for (int l = 0; l < LANES; l++) begin
            work_next[127 - 8 * (int'(cnt) * LANES + l) -: 8] = mode_q
                ? inv_sbox(work[127 - 8 * (int'(cnt) * LANES + l) -: 8])
                : fwd_sbox(work[127 - 8 * (int'(cnt) * LANES + l) -: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= state_in;
                        mode_q   <= mode;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    work <= work_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(GROUPS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = ~in_ready;
    assign state_out = work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb/tb_sub_bytes_engine.sv - Self-checking bench for sub_bytes_engine at LANES 4, 1 and 16
module tb_sub_bytes_engine;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         mode;
    logic         out_ready;
    logic [127:0] state_in;

    logic         rdy  [3];
    logic         vld  [3];
    logic         bsy  [3];
    logic [127:0] sout [3];

    int lanes_of [3] = '{4, 1, 16};
    int total = 0;
    int bad   = 0;

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    sub_bytes_engine #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .mode(mode),
        .state_in(state_in), .out_valid(vld[0]), .out_ready(out_ready), .state_out(sout[0]), .busy(bsy[0]));
    sub_bytes_engine #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .mode(mode),
        .state_in(state_in), .out_valid(vld[1]), .out_ready(out_ready), .state_out(sout[1]), .busy(bsy[1]));
    sub_bytes_engine #(.LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .mode(mode),
        .state_in(state_in), .out_valid(vld[2]), .out_ready(out_ready), .state_out(sout[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic m, input logic [127:0] d);
        logic [127:0] r;
        logic [7:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = d[127 - 8 * k -: 8];
            r[127 - 8 * k -: 8] = m ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic all_ready();
        return rdy[0] & rdy[1] & rdy[2];
    endfunction

    task automatic check_idle(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_rdy%0d", tag, i), 128'(rdy[i]), 128'd1);
            check($sformatf("%s_busy%0d", tag, i), 128'(bsy[i]), 128'd0);
            check($sformatf("%s_vld%0d", tag, i), 128'(vld[i]), 128'd0);
        end
    endtask

    // One block through all three engines with out_ready held low, garbage on the inputs,
    // then a single-cycle release. res returns the LANES=1 engine's output.
    task automatic run_block(input logic m, input logic [127:0] d, input string tag,
                             output logic [127:0] res);
        int           lat  [3];
        logic [127:0] snap [3];
        logic [127:0] exp;
        int           cyc;
        exp = model(m, d);
        cyc = 0;
        while (!all_ready() && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_ready"}, 128'(all_ready()), 128'd1);
        @(negedge clk);
        in_valid  = 1'b1;
        mode      = m;
        state_in  = d;
        out_ready = 1'b0;
        @(posedge clk); #1;
        lat = '{-1, -1, -1};
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            mode     = 1'($urandom);
            state_in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && vld[i]) begin
                    lat[i]  = c;
                    snap[i] = sout[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_lat%0d", tag, i), 128'(lat[i]), 128'(16 / lanes_of[i]));
            check($sformatf("%s_data%0d", tag, i), sout[i], exp);
            check($sformatf("%s_hold%0d", tag, i), sout[i], snap[i]);
            check($sformatf("%s_bp_rdy%0d", tag, i), 128'(rdy[i]), 128'd0);
        end
        res = sout[1];
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_idle({tag, "_rel"});
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] d;
        logic         m;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                fwd_tab[r * 16 + c] = sbox_rows[r][127 - 8 * c -: 8];
        for (int i = 0; i < 256; i++)
            inv_tab[fwd_tab[i]] = 8'(i);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        #23;
        check_idle("reset");
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_out%0d", i), sout[i], 128'd0);
        rst_n = 1'b1;

        run_block(1'b0, 128'h000102030405060708090a0b0c0d0e0f, "vec_fwd", res);
        check("vec_fwd_const", res, 128'h637c777bf26b6fc53001672bfed7ab76);
        run_block(1'b1, 128'h000102030405060708090a0b0c0d0e0f, "vec_inv", res);
        check("vec_inv_const", res, 128'h52096ad53036a538bf40a39e81f3d7fb);

        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) d[127 - 8 * k -: 8] = 8'(b * 16 + k);
            run_block(1'b0, d, $sformatf("sweep_f%0d", b), res);
            if (b == 5) check("s_53", 128'(res[127 - 24 -: 8]), 128'hed);
            run_block(1'b1, res, $sformatf("round_i%0d", b), res);
            check($sformatf("round_fi%0d", b), res, d);
            run_block(1'b1, d, $sformatf("sweep_i%0d", b), res);
            if (b == 0) check("inv_00", 128'(res[127 -: 8]), 128'h52);
            run_block(1'b0, res, $sformatf("round_f%0d", b), res);
            check($sformatf("round_if%0d", b), res, d);
        end

        for (int n = 0; n < 6; n++) begin
            m = 1'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            run_block(m, d, $sformatf("rand%0d", n), res);
        end

        // Asynchronous abort two RUN cycles into a block.
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 1'b1;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("abort_busy_pre", 128'(bsy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        for (int i = 0; i < 3; i++)
            check($sformatf("abort_out%0d", i), sout[i], 128'd0);
        #4;
        rst_n = 1'b1;
        d = {$urandom, $urandom, $urandom, $urandom};
        run_block(1'b0, d, "post_abort", res);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
